trojan_guarded_alu_pipe: RTL and testbench

Parametrised, registered successor to the combinational Trojan-protected ALU.
- Performs ADD/SUB/AND/XOR on WIDTH-bit operands through a valid/ready pipeline stage.
- Monitors accepted transactions for a configurable trigger signature.
- Escalates repeated triggers through a NORMAL/ALERT/LOCKOUT state machine with a timed lockout.
- Sits between the operand source and the result consumer in the protected datapath.

---
 rtl/trojan_guarded_alu_pipe.sv | 166 ++++++++++++++++
 tb/tb_trojan_guarded_alu_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_guarded_alu_pipe.sv
// Registered ADD/SUB/AND/XOR stage with trigger-signature detection and NORMAL/ALERT/LOCKOUT escalation.
// Optional trigger capture log enabled by defining TPS_TRIG_LOG_EN.
module trojan_guarded_alu_pipe #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] SIG_A       = WIDTH'(8'hAA),
  parameter logic [WIDTH-1:0] SIG_B       = WIDTH'(8'h55),
  parameter int unsigned      THRESH      = 3,
  parameter int unsigned      LOCK_CYCLES = 16,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             mitigation_active,
  output logic             lockout,
`ifdef TPS_TRIG_LOG_EN
  output logic [WIDTH-1:0] trig_log_a,
  output logic [WIDTH-1:0] trig_log_b,
  output logic             trig_log_valid,
`endif
  output logic [CNT_W-1:0] trigger_count
);

  localparam int unsigned SW = (THRESH > 1) ? $clog2(THRESH + 1) : 1;
  localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {ST_NORMAL, ST_ALERT, ST_LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   strike_q, strike_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            accept, trigger, mitigate;
  logic [WIDTH:0]  arith;
  logic [WIDTH-1:0] alu_res;
  logic            alu_carry;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign trigger  = accept && (opcode == 2'b11) && (a == SIG_A) && (b == SIG_B);
  assign mitigate = trigger || (state_q == ST_LOCKOUT);

  // ALU: arithmetic at WIDTH+1 bits so the MSB is carry-out / borrow
  always_comb begin
    arith     = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (opcode)
      2'b00: begin
        arith     = {1'b0, a} + {1'b0, b};
        alu_res   = arith[WIDTH-1:0];
        alu_carry = arith[WIDTH];
      end
      2'b01: begin
        arith     = {1'b0, a} - {1'b0, b};
        alu_res   = arith[WIDTH-1:0];
        alu_carry = arith[WIDTH];
      end
      2'b10:   alu_res = a & b;
      default: alu_res = a ^ b;
    endcase
  end

  // Escalation next-state; lock timer runs every cycle regardless of handshake
  always_comb begin
    state_d  = state_q;
    strike_d = strike_q;
    timer_d  = timer_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (trigger) begin
          if (THRESH == 1) begin
            state_d  = ST_LOCKOUT;
            strike_d = '0;
            timer_d  = TW'(LOCK_CYCLES - 1);
          end else begin
            state_d  = ST_ALERT;
            strike_d = SW'(1);
          end
        end
      end
      ST_ALERT: begin
        if (trigger) begin
          if (strike_q + SW'(1) == SW'(THRESH)) begin
            state_d  = ST_LOCKOUT;
            strike_d = '0;
            timer_d  = TW'(LOCK_CYCLES - 1);
          end else begin
            strike_d = strike_q + SW'(1);
          end
        end else if (accept) begin
          state_d  = ST_NORMAL;
          strike_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (trigger) begin
          timer_d = TW'(LOCK_CYCLES - 1);
        end else if (timer_q == '0) begin
          state_d = ST_NORMAL;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d  = ST_NORMAL;
        strike_d = '0;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_NORMAL;
      strike_q          <= '0;
      timer_q           <= '0;
      lockout           <= 1'b0;
      out_valid         <= 1'b0;
      result            <= '0;
      carry             <= 1'b0;
      mitigation_active <= 1'b0;
      trigger_count     <= '0;
    end else begin
      state_q  <= state_d;
      strike_q <= strike_d;
      timer_q  <= timer_d;
      lockout  <= (state_d == ST_LOCKOUT);
      if (accept) begin
        out_valid         <= 1'b1;
        result            <= mitigate ? '0 : alu_res;
        carry             <= !mitigate && alu_carry;
        mitigation_active <= mitigate;
      end else if (out_ready) begin
        out_valid         <= 1'b0;
        mitigation_active <= 1'b0;
      end
      if (trigger && (trigger_count != '1)) begin
        trigger_count <= trigger_count + CNT_W'(1);
      end
    end
  end

`ifdef TPS_TRIG_LOG_EN
  // Sticky capture of the most recent triggering operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_log_a     <= '0;
      trig_log_b     <= '0;
      trig_log_valid <= 1'b0;
    end else if (trigger) begin
      trig_log_a     <= a;
      trig_log_b     <= b;
      trig_log_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trojan_guarded_alu_pipe.sv
// Directed bench for trojan_guarded_alu_pipe with a cycle-level reference model checked every negedge.
module tb_trojan_guarded_alu_pipe;

  localparam int LOCK_CYCLES = 16;
  localparam int THRESH      = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [1:0] opcode;
  logic       carry, mitigation_active, lockout;
  logic [7:0] trigger_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic       m_ov, m_carry, m_mit;
  logic [7:0] m_res;
  int         m_cnt, m_streak, m_lock_left;

  trojan_guarded_alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .mitigation_active(mitigation_active),
    .lockout(lockout), .trigger_count(trigger_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov = 0; m_res = 0; m_carry = 0; m_mit = 0;
      m_cnt = 0; m_streak = 0; m_lock_left = 0;
    end else begin
      bit acc, trig, locked;
      int full;
      acc    = in_valid && (!m_ov || out_ready);
      trig   = acc && opcode == 2'b11 && a == 8'hAA && b == 8'h55;
      locked = m_lock_left > 0;
      if (acc) begin
        full = 0;
        case (opcode)
          2'b00: full = int'(a) + int'(b);
          2'b01: full = int'(a) - int'(b);
          2'b10: full = int'(a & b);
          default: full = int'(a ^ b);
        endcase
        m_ov = 1;
        m_mit = trig || locked;
        m_res = m_mit ? 8'h00 : 8'(full & 255);
        m_carry = !m_mit && ((opcode == 2'b00 && full > 255) || (opcode == 2'b01 && full < 0));
      end else if (out_ready) begin
        m_ov = 0;
        m_mit = 0;
      end
      if (trig && m_cnt < 255) m_cnt++;
      if (locked) begin
        if (trig) m_lock_left = LOCK_CYCLES;
        else m_lock_left--;
      end else if (trig) begin
        m_streak++;
        if (m_streak == THRESH) begin
          m_streak = 0;
          m_lock_left = LOCK_CYCLES;
        end
      end else if (acc) begin
        m_streak = 0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    cmp("m_out_valid", 32'(out_valid), 32'(m_ov));
    cmp("m_in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
    cmp("m_lockout", 32'(lockout), 32'(m_lock_left > 0));
    cmp("m_trig_cnt", 32'(trigger_count), 32'(m_cnt));
    cmp("m_mitigation", 32'(mitigation_active), 32'(m_mit));
    if (m_ov) begin
      cmp("m_result", 32'(result), 32'(m_res));
      cmp("m_carry", 32'(carry), 32'(m_carry));
    end
  end

  // Present one operand set and hold until accepted; returns 1ns after the accepting edge
  task automatic xfer(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] op);
    bit ok;
    ok = 0;
    in_valid = 1'b1; a = ta; b = tb_v; opcode = op;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL xfer_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  logic [7:0] tv_a [5] = '{8'hAA, 8'hAA, 8'hFF, 8'h00, 8'h07};
  logic [7:0] tv_b [5] = '{8'h55, 8'h54, 8'h01, 8'h01, 8'h07};
  logic [1:0] tv_o [5] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b01};
  logic [7:0] tv_r [5] = '{8'h00, 8'hFE, 8'h00, 8'hFF, 8'h00};
  logic       tv_c [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_out_valid", 32'(out_valid), 0);
    cmp("rst_lockout", 32'(lockout), 0);
    cmp("rst_count", 32'(trigger_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with carry
    xfer(8'hF0, 8'h20, 2'b00);
    cmp("t1_valid", 32'(out_valid), 1);
    cmp("t1_result", 32'(result), 32'h10);
    cmp("t1_carry", 32'(carry), 1);
    cmp("t1_mit", 32'(mitigation_active), 0);

    // Near-miss signatures and arithmetic edges
    for (int i = 0; i < 5; i++) begin
      xfer(tv_a[i], tv_b[i], tv_o[i]);
      cmp("tv_result", 32'(result), 32'(tv_r[i]));
      cmp("tv_carry", 32'(carry), 32'(tv_c[i]));
      cmp("tv_mit", 32'(mitigation_active), 0);
    end

    // SUB with borrow under backpressure
    xfer(8'h05, 8'h07, 2'b01);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp("t2_valid", 32'(out_valid), 1);
      cmp("t2_result", 32'(result), 32'hFE);
      cmp("t2_carry", 32'(carry), 1);
      cmp("t2_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 cmp("t2_release", 32'(in_ready), 1);
    @(posedge clk); #1;
    cmp("t2_drop", 32'(out_valid), 0);

    // Single trigger then clean XOR
    xfer(8'hAA, 8'h55, 2'b11);
    cmp("t3_trig_result", 32'(result), 0);
    cmp("t3_trig_mit", 32'(mitigation_active), 1);
    xfer(8'h0F, 8'hF0, 2'b11);
    cmp("t3_xor_result", 32'(result), 32'hFF);
    cmp("t3_xor_mit", 32'(mitigation_active), 0);
    cmp("t3_count", 32'(trigger_count), 1);

    // Three triggers force lockout for 16 cycles
    repeat (3) xfer(8'hAA, 8'h55, 2'b11);
    cmp("t4_lockout", 32'(lockout), 1);
    cmp("t4_count", 32'(trigger_count), 4);
    xfer(8'h01, 8'h01, 2'b00);
    cmp("t4_lock_result", 32'(result), 0);
    cmp("t4_lock_mit", 32'(mitigation_active), 1);
    n = 2;
    for (int i = 0; i < 40 && lockout; i++) begin
      @(posedge clk); #1;
      if (lockout) n++;
    end
    cmp("t4_lock_cycles", 32'(n), 16);
    xfer(8'h01, 8'h01, 2'b00);
    cmp("t4_after_result", 32'(result), 32'h02);
    cmp("t4_after_mit", 32'(mitigation_active), 0);

    // Re-trigger at timer==3 reloads; clean accept on expiry edge is still mitigated
    repeat (3) xfer(8'hAA, 8'h55, 2'b11);
    repeat (12) @(posedge clk);
    #1;
    xfer(8'hAA, 8'h55, 2'b11);
    cmp("t5_lockout", 32'(lockout), 1);
    cmp("t5_count", 32'(trigger_count), 8);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      cmp("t5_hold", 32'(lockout), 1);
    end
    xfer(8'h01, 8'h01, 2'b00);
    cmp("t5_expiry_lockout", 32'(lockout), 0);
    cmp("t5_expiry_result", 32'(result), 0);
    cmp("t5_expiry_mit", 32'(mitigation_active), 1);

    // Async reset mid-lockout with a held result
    repeat (3) xfer(8'hAA, 8'h55, 2'b11);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("t6_pre_lockout", 32'(lockout), 1);
    cmp("t6_pre_valid", 32'(out_valid), 1);
    cmp("t6_pre_count", 32'(trigger_count), 11);
    #2 rst_n = 1'b0;
    #1;
    cmp("t6_rst_valid", 32'(out_valid), 0);
    cmp("t6_rst_result", 32'(result), 0);
    cmp("t6_rst_carry", 32'(carry), 0);
    cmp("t6_rst_mit", 32'(mitigation_active), 0);
    cmp("t6_rst_lockout", 32'(lockout), 0);
    cmp("t6_rst_count", 32'(trigger_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    xfer(8'hC3, 8'h0F, 2'b10);
    cmp("t6_and_result", 32'(result), 32'h03);
    cmp("t6_and_mit", 32'(mitigation_active), 0);
    cmp("t6_and_lockout", 32'(lockout), 0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
